cpu_prog_feeder: RTL and testbench

- Instruction/data source that sits directly upstream of the cpu and drives its DIN and Run inputs.
- Holds a small loadable program RAM and a program counter.
- Issues one instruction word per instruction, plus the following immediate word when the opcode is mvi.
- Paces issue on the cpu's Done, so programs run back-to-back without a hand-timed stimulus.
- Watchdog flags a cpu that never completes an instruction.

---
 rtl/cpu_prog_feeder_pkg.sv | 31 +++
 rtl/cpu_prog_feeder_prog_ram.sv | 24 ++
 rtl/cpu_prog_feeder.sv | 160 ++++++++++++++++
 tb/tb_cpu_prog_feeder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_prog_feeder_pkg.sv
// Shared definitions for the cpu program feeder: cpu opcodes and feeder state encodings.
package cpu_prog_feeder_pkg;

    // Opcode field DIN[8:6]; the cpu decoder uses the same values.
    typedef enum logic [2:0] {
        OpMv  = 3'b000,
        OpMvi = 3'b001,
        OpAdd = 3'b010,
        OpSub = 3'b011
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StImm,
        StWait,
        StHalt
    } state_e;

    // Outcome of the check made before every instruction issue.
    typedef enum logic [1:0] {
        PreIssue,
        PreHalt,
        PreFault
    } pre_e;

    function automatic logic [2:0] opcode_of(input logic [15:0] word);
        return word[8:6];
    endfunction

endpackage

// File: rtl/cpu_prog_feeder_prog_ram.sv
// Program RAM: DEPTH x 16, synchronous write, combinational read.
module cpu_prog_feeder_prog_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_prog_feeder.sv
// Feeds a loaded program to the cpu one instruction (plus mvi immediate) at a time,
// paced by the cpu's Done, with a watchdog that aborts on a stalled instruction.
module cpu_prog_feeder
    import cpu_prog_feeder_pkg::*;
#(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned AW      = 6,
    parameter int unsigned TIMEOUT = 15,
    parameter logic [2:0]  MVI_OP  = OpMvi
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Start,
    input  logic [AW:0]   Length,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic          Done,
    output logic [15:0]   DIN,
    output logic          Run,
    output logic [AW:0]   PC,
    output logic          Busy,
    output logic          Halted,
    output logic          Error
);

    localparam int unsigned WdW       = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
    localparam logic [AW:0] DepthLen  = (AW + 1)'(DEPTH);

    state_e         state;
    logic [AW:0]    len;
    logic [WdW-1:0] wd;

    logic           wr_ok;
    logic           idle_like;
    logic           launch;
    logic [AW-1:0]  rd_addr;
    logic [15:0]    ram_word;
    logic [15:0]    rd_word;
    logic [AW:0]    len_in;
    logic [AW:0]    chk_pc;
    logic [AW:0]    chk_len;
    logic [AW+1:0]  chk_inc;
    pre_e           pre;

    assign wr_ok  = wr_en && !Busy;
    assign len_in = (Length > DepthLen) ? DepthLen : Length;

    cpu_prog_feeder_prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_ram (
        .clock (Clock),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (ram_word)
    );

    // A launch from IDLE/HALT checks address 0 against the incoming Length.
    always_comb begin
        idle_like = (state == StIdle) || (state == StHalt);
        rd_addr   = idle_like ? '0 : PC[AW-1:0];
        chk_pc    = idle_like ? '0 : PC;
        chk_len   = idle_like ? len_in : len;
        chk_inc   = {1'b0, chk_pc} + 1'b1;
        // Forward a same-cycle write so a write issued alongside Start is seen.
        rd_word   = (wr_ok && (wr_addr == rd_addr)) ? wr_data : ram_word;
        if (chk_pc >= chk_len) begin
            pre = PreHalt;
        end else if ((opcode_of(rd_word) == MVI_OP) && (chk_inc >= {1'b0, chk_len})) begin
            pre = PreFault;
        end else begin
            pre = PreIssue;
        end
        launch = (idle_like && Start) || (((state == StImm) || (state == StWait)) && Done);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= StIdle;
            len    <= '0;
            wd     <= '0;
            DIN    <= '0;
            Run    <= 1'b0;
            PC     <= '0;
            Busy   <= 1'b0;
            Halted <= 1'b0;
            Error  <= 1'b0;
        end else begin
            Run <= 1'b0;
            unique case (state)
                StIdle, StHalt: begin
                    if (Start) begin
                        len   <= len_in;
                        PC    <= '0;
                        Error <= 1'b0;
                    end
                end
                StIssue: begin
                    if (opcode_of(DIN) == MVI_OP) begin
                        state <= StImm;
                        DIN   <= rd_word;
                        PC    <= PC + 1'b1;
                    end else begin
                        state <= StWait;
                    end
                end
                StImm: begin
                    if (!Done) begin
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (Done) begin
                        wd <= '0;
                    end else if (wd == WdLast) begin
                        wd     <= '0;
                        state  <= StHalt;
                        Busy   <= 1'b0;
                        Halted <= 1'b1;
                        Error  <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase

            // Later assignments here override the PC/Error defaults set above.
            if (launch) begin
                unique case (pre)
                    PreIssue: begin
                        state  <= StIssue;
                        DIN    <= rd_word;
                        Run    <= 1'b1;
                        PC     <= chk_pc + 1'b1;
                        Busy   <= 1'b1;
                        Halted <= 1'b0;
                    end
                    PreHalt: begin
                        state  <= StHalt;
                        Busy   <= 1'b0;
                        Halted <= 1'b1;
                    end
                    PreFault: begin
                        state  <= StHalt;
                        Busy   <= 1'b0;
                        Halted <= 1'b1;
                        Error  <= 1'b1;
                    end
                    default: state <= StHalt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_prog_feeder.sv
// Directed bench for cpu_prog_feeder with hand-computed expectations.
module tb_cpu_prog_feeder;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [6:0]  Length = '0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        Done = 1'b0;
    logic [15:0] DIN;
    logic        Run;
    logic [6:0]  PC;
    logic        Busy;
    logic        Halted;
    logic        Error;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_prog_feeder dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .Length  (Length),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .Done    (Done),
        .DIN     (DIN),
        .Run     (Run),
        .PC      (PC),
        .Busy    (Busy),
        .Halted  (Halted),
        .Error   (Error)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [5:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start(input logic [6:0] n);
        Start  = 1'b1;
        Length = n;
        tick();
        Start  = 1'b0;
    endtask

    // From an ISSUE cycle of a non-mvi instruction: T0 then T1 with Done.
    task automatic done_cycle();
        Done = 1'b0;
        tick();
        Done = 1'b1;
        tick();
        Done = 1'b0;
    endtask

    task automatic check_issue(input string tag, input logic [15:0] din, input logic [6:0] pc);
        check({tag, ".run"}, 32'(Run), 32'd1);
        check({tag, ".din"}, 32'(DIN), 32'(din));
        check({tag, ".pc"}, 32'(PC), 32'(pc));
    endtask

    task automatic check_halt(input string tag, input logic [6:0] pc, input logic err);
        check({tag, ".halted"}, 32'(Halted), 32'd1);
        check({tag, ".busy"}, 32'(Busy), 32'd0);
        check({tag, ".run"}, 32'(Run), 32'd0);
        check({tag, ".pc"}, 32'(PC), 32'(pc));
        check({tag, ".error"}, 32'(Error), 32'(err));
    endtask

    initial begin
        // Reset state
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        check("rst.din", 32'(DIN), 32'h0);
        check("rst.run", 32'(Run), 32'd0);
        check("rst.pc", 32'(PC), 32'd0);
        check("rst.busy", 32'(Busy), 32'd0);
        check("rst.halted", 32'(Halted), 32'd0);
        check("rst.error", 32'(Error), 32'd0);

        // mvi R0,#10 with Done in the IMM cycle
        load(6'd0, 16'h0040);
        load(6'd1, 16'h000A);
        start(7'd2);
        check_issue("mvi.issue", 16'h0040, 7'd1);
        check("mvi.busy", 32'(Busy), 32'd1);
        tick();
        check("mvi.imm.run", 32'(Run), 32'd0);
        check("mvi.imm.din", 32'(DIN), 32'h000A);
        check("mvi.imm.pc", 32'(PC), 32'd2);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check_halt("mvi.halt", 7'd2, 1'b0);
        check("mvi.halt.din", 32'(DIN), 32'h000A);

        // mv R1,R0 ; mv R2,R1 : Run every 2 cycles
        load(6'd0, 16'h0008);
        load(6'd1, 16'h0011);
        start(7'd2);
        check_issue("mv.i0", 16'h0008, 7'd1);
        tick();
        check("mv.t1.run", 32'(Run), 32'd0);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check_issue("mv.i1", 16'h0011, 7'd2);
        done_cycle();
        check_halt("mv.halt", 7'd2, 1'b0);

        // add R0,R1 with Done held low: watchdog abort after 15 WAIT cycles
        load(6'd0, 16'h0081);
        start(7'd1);
        check_issue("wd.issue", 16'h0081, 7'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            check("wd.wait.run", 32'(Run), 32'd0);
        end
        check("wd.last.busy", 32'(Busy), 32'd1);
        check("wd.last.error", 32'(Error), 32'd0);
        tick();
        check_halt("wd.halt", 7'd1, 1'b1);

        // Done in HALT is ignored
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check("halt.done.halted", 32'(Halted), 32'd1);

        // Length=1 ending on mvi: no Run, immediate fault
        load(6'd0, 16'h0040);
        start(7'd1);
        check_halt("trunc", 7'd0, 1'b1);

        // Reset during WAIT of a 3-word program, then rerun from retained RAM
        load(6'd0, 16'h0008);
        load(6'd1, 16'h0011);
        load(6'd2, 16'h0081);
        start(7'd3);
        check_issue("rr.issue", 16'h0008, 7'd1);
        check("rr.error.cleared", 32'(Error), 32'd0);
        tick();
        check("rr.wait.busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("rr.rst.din", 32'(DIN), 32'h0);
        check("rr.rst.run", 32'(Run), 32'd0);
        check("rr.rst.pc", 32'(PC), 32'd0);
        check("rr.rst.busy", 32'(Busy), 32'd0);
        check("rr.rst.halted", 32'(Halted), 32'd0);
        check("rr.rst.error", 32'(Error), 32'd0);
        start(7'd3);
        check_issue("rr.i0", 16'h0008, 7'd1);
        done_cycle();
        check_issue("rr.i1", 16'h0011, 7'd2);
        done_cycle();
        check_issue("rr.i2", 16'h0081, 7'd3);
        done_cycle();
        check_halt("rr.halt", 7'd3, 1'b0);

        // Write and Start while Busy are both dropped
        start(7'd3);
        check_issue("bw.i0", 16'h0008, 7'd1);
        tick();
        wr_en   = 1'b1;
        wr_addr = 6'd0;
        wr_data = 16'hFFFF;
        Start   = 1'b1;
        Length  = 7'd1;
        tick();
        wr_en   = 1'b0;
        Start   = 1'b0;
        check("bw.run", 32'(Run), 32'd0);
        check("bw.pc", 32'(PC), 32'd1);
        check("bw.busy", 32'(Busy), 32'd1);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check_issue("bw.i1", 16'h0011, 7'd2);
        done_cycle();
        check_issue("bw.i2", 16'h0081, 7'd3);
        done_cycle();
        check_halt("bw.halt", 7'd3, 1'b0);
        start(7'd1);
        check_issue("bw.rerun", 16'h0008, 7'd1);
        done_cycle();
        check_halt("bw.rerun.halt", 7'd1, 1'b0);

        // Write and Start in the same idle cycle: the new word is checked
        wr_en   = 1'b1;
        wr_addr = 6'd0;
        wr_data = 16'h0040;
        start(7'd1);
        wr_en   = 1'b0;
        check_halt("ws", 7'd0, 1'b1);

        // Length=0 halts at once with no error
        start(7'd0);
        check_halt("len0", 7'd0, 1'b0);

        // mvi with Done low in IMM goes through WAIT before the next issue
        load(6'd1, 16'h000A);
        start(7'd3);
        check_issue("iw.i0", 16'h0040, 7'd1);
        tick();
        check("iw.imm.din", 32'(DIN), 32'h000A);
        tick();
        check("iw.wait.busy", 32'(Busy), 32'd1);
        check("iw.wait.run", 32'(Run), 32'd0);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        check_issue("iw.i1", 16'h0081, 7'd3);
        done_cycle();
        check_halt("iw.halt", 7'd3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
